// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS ALU with iterative mul/div and HI/LO; define ALU_EARLY_TERM_EN for early MULT exit
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       F,
  input  logic             uns,
  input  logic             en,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             OF,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef ALU_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc, mcand, mul_next, div_next, prod;
  logic [WIDTH-1:0]   opb, hi, lo, bx, sum, a_mag, b_mag, quo, rem, fin_hi, fin_lo;
  logic [WIDTH+1:0]   diff;
  logic               op_div, q_neg, r_neg, done_r, carry, ovf, lt, a_neg, b_neg, start, last, div0;
  assign bx    = F[2] ? ~B : B;
  assign {carry, sum} = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, F[2]};
  assign ovf   = (A[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
  assign lt    = uns ? ~carry : sum[WIDTH-1] ^ ovf;
  assign OF    = (F == 4'b0010 | F == 4'b0110) & ovf;
  assign zero  = ~|Y;
  assign busy  = state != IDLE;
  assign stall = busy & en & F[3];
  assign done  = done_r;
  assign hi_q  = hi;
  assign lo_q  = lo;
  // single-cycle result mux; MFHI/MFLO see the committed HI/LO even mid-operation
  always_comb begin
    Y = '0;
    case (F)
      4'b0000: Y = A & B;
      4'b0001: Y = A | B;
      4'b0010: Y = sum;
      4'b0011: Y = A ^ B;
      4'b0100: Y = A & ~B;
      4'b0101: Y = A | ~B;
      4'b0110: Y = sum;
      4'b0111: Y = {{(WIDTH-1){1'b0}}, lt};
      4'b1010: Y = hi;
      4'b1011: Y = lo;
      default: Y = '0;
    endcase
  end
  assign start = en & (F[3:1] == 3'b100) & (state == IDLE);
  assign a_neg = ~uns & A[WIDTH-1];
  assign b_neg = ~uns & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  // shift-add on a 2W accumulator; restoring divide keeps {rem, quo} in acc
  assign mul_next = opb[0] ? acc + mcand : acc;
  assign diff     = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, opb};
  assign div_next = diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign last     = (count == CNT_W'(WIDTH-1)) | (EARLY & ~op_div & ~|opb[WIDTH-1:1]);
  // sign correction and divide-by-zero override applied in FIN; mcand holds raw A during DIV
  assign prod   = q_neg ? -acc : acc;
  assign quo    = acc[WIDTH-1:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign div0   = ~|opb;
  assign fin_hi = op_div ? (div0 ? mcand[WIDTH-1:0] : (r_neg ? -rem : rem)) : prod[2*WIDTH-1:WIDTH];
  assign fin_lo = op_div ? (div0 ? '1 : (q_neg ? -quo : quo)) : prod[WIDTH-1:0];
  // mul/div sequencer plus HI/LO writes from MTHI/MTLO and completed operations
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div <= F[0];
            acc    <= F[0] ? {{WIDTH{1'b0}}, a_mag} : '0;
            mcand  <= F[0] ? {{WIDTH{1'b0}}, A} : {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
            q_neg  <= a_neg ^ b_neg;
            r_neg  <= a_neg;
            count  <= '0;
            state  <= RUN;
          end else if (en & F == 4'b1100) hi <= A;
          else if (en & F == 4'b1101) lo <= A;
        end
        RUN: begin
          acc   <= op_div ? div_next : mul_next;
          mcand <= op_div ? mcand : mcand << 1;
          opb   <= op_div ? opb : opb >> 1;
          count <= count + 1'b1;
          if (last) begin
            state  <= FIN;
            done_r <= 1'b1;
          end
        end
        FIN: begin
          hi    <= fin_hi;
          lo    <= fin_lo;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed bench with a HI/LO scoreboard for alu_muldiv
module tb_alu_muldiv;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset, uns, en;
  logic [W-1:0] A, B;
  logic [3:0] F;
  logic [W-1:0] Y, hi_q, lo_q;
  logic zero, OF, busy, done, stall;
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] cur_hi, cur_lo;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .F(F), .uns(uns), .en(en),
    .Y(Y), .zero(zero), .OF(OF), .busy(busy), .done(done), .stall(stall),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    longint sa, sbv, q, r;
    sa  = u ? longint'({32'b0, a}) : longint'($signed(a));
    sbv = u ? longint'({32'b0, b}) : longint'($signed(b));
    if (f == 4'b1000) return u ? {32'b0, a} * {32'b0, b} : 64'(sa * sbv);
    if (b == '0) return {a, {W{1'b1}}};
    q = sa / sbv;
    r = sa % sbv;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int lat_of(input logic [3:0] f, input logic [W-1:0] b, input logic u);
`ifdef ALU_EARLY_TERM_EN
    logic [W-1:0] m;
    int steps;
    if (f != 4'b1000) return W + 1;
    m = (~u & b[W-1]) ? -b : b;
    steps = 1;
    while (steps < W && (m >> steps) != '0) steps++;
    return steps + 1;
`else
    return W + 1;
`endif
  endfunction

  task automatic comb(input string tag, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic u, input logic [W-1:0] ey, input logic eo);
    F = f; A = a; B = b; uns = u; en = 1'b0;
    #1;
    chk({tag, " Y"}, Y, ey);
    chk({tag, " OF"}, {31'b0, OF}, {31'b0, eo});
    chk({tag, " zero"}, {31'b0, zero}, {31'b0, ey == '0});
  endtask

  task automatic mt(input logic [3:0] f, input logic [W-1:0] a);
    @(negedge clk);
    F = f; A = a; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0; F = 4'b0000;
    if (f == 4'b1100) cur_hi = a; else cur_lo = a;
    chk("mt hi", hi_q, cur_hi);
    chk("mt lo", lo_q, cur_lo);
  endtask

  task automatic start_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    @(negedge clk);
    F = f; A = a; B = b; uns = u; en = 1'b1;
    exp_q.push_back(model(f, a, b, u));
    @(posedge clk);
    #1 en = 1'b0; F = 4'b0000; A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input int first);
    int lat;
    logic [2*W-1:0] e;
    lat = 0;
    for (int i = first; i <= 60; i++) begin
      @(negedge clk);
      chk("busy run", {31'b0, busy}, 32'd1);
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("done latency", lat, exp_lat);
    @(negedge clk);
    e = exp_q.pop_front();
    cur_hi = e[2*W-1:W];
    cur_lo = e[W-1:0];
    chk("result hi", hi_q, cur_hi);
    chk("result lo", lo_q, cur_lo);
    chk("done pulse end", {31'b0, done}, 32'd0);
    chk("busy end", {31'b0, busy}, 32'd0);
  endtask

  task automatic op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic u);
    start_op(f, a, b, u);
    wait_done(lat_of(f, b, u), 1);
  endtask

  initial begin
    logic saw_done;
    reset = 1'b1; en = 1'b0; F = 4'b0000; A = '0; B = '0; uns = 1'b0;
    cur_hi = '0; cur_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset hi", hi_q, 32'd0);
    chk("reset lo", lo_q, 32'd0);
    reset = 1'b0;
    comb("add ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b1);
    comb("sub zero", 4'b0110, 32'h5, 32'h5, 1'b0, 32'h0, 1'b0);
    comb("slt signed", 4'b0111, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h1, 1'b0);
    comb("slt unsigned", 4'b0111, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 1'b0);
    comb("slt min", 4'b0111, 32'h80000000, 32'h7FFFFFFF, 1'b0, 32'h1, 1'b0);
    comb("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0);
    comb("or", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hFFF0FFF0, 1'b0);
    comb("xor", 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h0FF00FF0, 1'b0);
    comb("andn", 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'h00F000F0, 1'b0);
    comb("orn", 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF0FFF0FF, 1'b0);
    comb("sub ovf", 4'b0110, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b1);
    comb("add wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0);
    comb("reserved", 4'b1110, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0);
    comb("mult idle Y", 4'b1000, 32'h5, 32'h3, 1'b0, 32'h0, 1'b0);
    mt(4'b1100, 32'hCAFEF00D);
    mt(4'b1101, 32'h12345678);
    comb("mfhi", 4'b1010, 32'h0, 32'h0, 1'b0, cur_hi, 1'b0);
    comb("mflo", 4'b1011, 32'h0, 32'h0, 1'b0, cur_lo, 1'b0);
    op(4'b1000, 32'hFFFFFFFD, 32'h7, 1'b0);
    op(4'b1000, 32'hFFFFFFFD, 32'h7, 1'b1);
    op(4'b1000, 32'h5, 32'h3, 1'b0);
    op(4'b1000, 32'h80000000, 32'h80000000, 1'b0);
    op(4'b1000, 32'hDEADBEEF, 32'h0, 1'b1);
    op(4'b1001, 32'hFFFFFFF9, 32'h2, 1'b0);
    op(4'b1001, 32'h7, 32'hFFFFFFFE, 1'b0);
    op(4'b1001, 32'hFFFFFFF9, 32'h0, 1'b0);
    op(4'b1001, 32'hFFFFFFF9, 32'h0, 1'b1);
    op(4'b1001, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    op(4'b1001, 32'hFFFFFFFF, 32'h3, 1'b1);
    start_op(4'b1000, 32'hFFFFFFFD, 32'h7, 1'b1);
    @(negedge clk);
    F = 4'b1101; A = 32'h1234; en = 1'b1;
    #1;
    chk("mtlo stall", {31'b0, stall}, 32'd1);
    F = 4'b1011;
    #1;
    chk("mflo busy old", Y, cur_lo);
    chk("mflo stall", {31'b0, stall}, 32'd1);
    F = 4'b1101;
    @(posedge clk);
    #1;
    chk("mtlo ignored", lo_q, cur_lo);
    en = 1'b0; F = 4'b0000;
    wait_done(lat_of(4'b1000, 32'h7, 1'b1), 2);
    start_op(4'b1001, 32'h64, 32'h7, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid reset busy", {31'b0, busy}, 32'd0);
    chk("mid reset hi", hi_q, 32'd0);
    chk("mid reset lo", lo_q, 32'd0);
    void'(exp_q.pop_back());
    cur_hi = '0; cur_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    chk("no done after reset", {31'b0, saw_done}, 32'd0);
    chk("idle after reset", {31'b0, busy}, 32'd0);
    op(4'b1001, 32'h64, 32'h7, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised successor to the single-cycle ALU for the MIPS datapath.
- Keeps single-cycle logic/add/sub/set-less-than ops; result, zero and OF are combinational.
- Adds an iterative multiply/divide unit with HI/LO registers, a busy/done handshake and a stall output for the control unit.
- Sits in the execute stage; the control unit holds the PC while stall=1.

Parameters:
WIDTH, 32, datapath width in bits (≥8, even); A, B, Y, HI, LO are all WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk    in   1      single clock, rising edge
reset  in   1      asynchronous, active-high; clears all state
A      in   WIDTH  operand A (dividend / multiplicand)
B      in   WIDTH  operand B (divisor / multiplier)
F      in   4      operation select (encoding below)
uns    in   1      unsigned mode for SLT, MULT, DIV
en     in   1      instruction valid; qualifies MULT/DIV/MTHI/MTLO
Y      out  WIDTH  result (combinational)
zero   out  1      ~|Y
OF     out  1      signed overflow, ADD/SUB only, else 0
busy   out  1      mul/div in progress
done   out  1      one-cycle pulse when HI/LO are written by mul/div
stall  out  1      busy & en & F[3]
hi_q   out  WIDTH  HI register (debug/trace)
lo_q   out  WIDTH  LO register

Behaviour:
Encoding (F):
- 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 A&~B; 0101 A|~B; 0110 SUB.
- 0111 SLT: signed = sum[W-1]^OF; uns=1 uses ~carry-out of A+~B+1. Y={0..0,lt}.
- 1000 MULT; 1001 DIV; 1010 MFHI (Y=HI); 1011 MFLO (Y=LO); 1100 MTHI; 1101 MTLO; 1110/1111 reserved, Y=0.
- Y=0 for F=1000/1001/1100/1101.

Arithmetic:
- SUB is A+~B+1.
- OF = (A[W-1]==B'[W-1]) & (sum[W-1]!=A[W-1]), where B' is the post-invert operand.
- MULT: full 2W-bit product; HI=upper W bits, LO=lower W bits.
- DIV signed: quotient truncates toward zero; remainder takes the sign of A; LO=quotient, HI=remainder.
- Divide by zero: LO=all ones, HI=A (both modes).
- Signed MIN/-1: LO=MIN, HI=0.

FSM: IDLE, RUN, FIN.
- IDLE: on en & (F==1000 | F==1001), latch |A|, |B|, result-sign flags (uns=1 means no abs/sign), op, count=0; go to RUN.
- RUN: one shift-add (mul) or restoring subtract (div) step per cycle; exit after WIDTH steps to FIN.
- FIN: apply sign correction, write HI/LO, done=1, go to IDLE.
- busy = (state!=IDLE).

Timing:
- Start sampled at edge k; busy=1 in cycles k+1 .. k+WIDTH+1.
- done=1 in cycle k+WIDTH+1; new HI/LO visible from k+WIDTH+2.
- Latency WIDTH+2 cycles to a readable HI/LO.

Boundary rules:
- MTHI/MTLO (en=1) write HI/LO at the next edge only in IDLE.
- While busy, MULT/DIV/MTHI/MTLO/MFHI/MFLO assert stall; writes and new starts are ignored.
- MFHI/MFLO read the old HI/LO while busy.
- Start and MTHI never coincide (single F).
- Reset anytime (including mid-RUN): state=IDLE, HI=LO=0, busy=done=0, count=0; the in-flight op is discarded.
- Operands are latched at start; A/B changes during RUN have no effect.

Optional Feature:
ALU_EARLY_TERM_EN
- Defined: MULT leaves RUN as soon as the remaining multiplier magnitude is zero (after at least 1 step); the product is unchanged. DIV latency is unchanged.
- Undefined: fixed WIDTH-step RUN for both ops.

Test Plan:
1. WIDTH=32, F=0010, A=7FFFFFFF, B=1 → Y=80000000, OF=1, zero=0; F=0110, A=B=5 → Y=0, zero=1.
2. F=0111, A=FFFFFFFF, B=1: uns=0 → Y=1; uns=1 → Y=0.
3. MULT signed, A=FFFFFFFD (-3), B=7, en pulse at edge k → busy k+1..k+33, done at k+33, HI=FFFFFFFF, LO=FFFFFFEB; uns=1 → HI=6, LO=FFFFFFEB.
4. DIV signed, A=-7, B=2 → LO=FFFFFFFD, HI=FFFFFFFF; B=0 → LO=FFFFFFFF, HI=A; A=80000000, B=FFFFFFFF → LO=80000000, HI=0.
5. MTLO A=1234 issued while busy → stall=1, LO unchanged; reset asserted mid-RUN → busy=0 immediately, HI=LO=0, no done pulse.
6. With ALU_EARLY_TERM_EN: MULT A=5, B=3 → done within 3 cycles of start, HI=0, LO=F; without the macro → done at k+33.
